// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment display path
//
// Purpose:
//   Common definitions for the display back-end and the blocks that reuse
//   its decoder (alarm display, etc.).
//
// Contents:
//   SEG_OFF     - SevenSegment value with every segment and the DP dark
//   DRV_OFF     - SegmentDrivers value with every digit disabled
//   digit_idx_t - 2-bit index selecting one of the four display digits
//   SEG_TABLE   - active-high gfedcba pattern for each 4-bit code 0..F
//   seg_pattern - table lookup helper

package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] DRV_OFF = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Packed so that SEG_TABLE[code] selects the pattern for that code:
    // the first element listed is entry 15 (F), the last is entry 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational 4-bit code to seven-segment pattern decoder
//
// Purpose:
//   Converts a hexadecimal digit code into the active-high gfedcba segment
//   pattern. Polarity inversion for the board is left to the caller so the
//   decoder can serve both common-anode and common-cathode users.
//
// Ports:
//   code - 4-bit digit code, 0..F
//   seg  - active-high pattern, [6:0] = g,f,e,d,c,b,a

module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(code);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode display driver
//
// Purpose:
//   Scans four digit codes onto a common-anode seven-segment display, one
//   digit per slot of SCAN_DIV clocks. Inputs are snapshotted once per frame
//   so a display update never tears, every slot opens with BLANK_CYCLES of
//   all-dark dead time to stop ghosting, and a 4-bit PWM sets brightness.
//
// Parameters:
//   SCAN_DIV     - clocks per digit slot, at least BLANK_CYCLES+2
//   BLANK_CYCLES - dark clocks at the start of every slot, at least 1
//
// Ports:
//   Clk_100M       - system clock
//   Reset          - asynchronous, active-high
//   Digits         - four digit codes, [3:0] = digit 0 (rightmost)
//   DP             - decimal point per digit, 1 = lit
//   Blank          - per-digit blank, 1 = digit dark
//   Brightness     - 0 = off .. 15 = full on
//   SegmentDrivers - digit enables, active-low, bit n = digit n
//   SevenSegment   - segments, active-low, [7] = DP, [6:0] = g..a
//   FrameStart     - one-cycle pulse in the cycle after the shadow load

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        Clk_100M,
    input  logic        Reset,
    input  logic [15:0] Digits,
    input  logic [3:0]  DP,
    input  logic [3:0]  Blank,
    input  logic [3:0]  Brightness,
    output logic [3:0]  SegmentDrivers,
    output logic [7:0]  SevenSegment,
    output logic        FrameStart
);

    localparam int PC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYCLES);

    // Scan timing state
    logic [PC_W-1:0] pc;
    digit_idx_t      idx;
    logic [3:0]      pw;
    logic            load_pending;

    // Per-frame snapshot of the inputs
    logic [15:0]     sh_digits;
    logic [3:0]      sh_dp;
    logic [3:0]      sh_blank;
    logic [3:0]      sh_bright;

    // Combinational decisions for the current cycle
    logic            wrap;
    logic            frame_end;
    logic            load;
    logic            on_pwm;
    logic            past_blank;
    logic            lit;
    logic [3:0]      cur_code;
    logic [6:0]      cur_pattern;
    logic [3:0]      drv_next;
    logic [7:0]      seg_next;

    always_comb begin
        wrap      = (pc == PC_LAST);
        frame_end = wrap && (idx == 2'd3);
        // The first clock out of reset loads immediately so the display
        // never shows the all-zero reset snapshot for a whole frame.
        load      = load_pending || frame_end;
    end

    // Prescaler, digit index and free-running PWM counter
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            pc  <= '0;
            idx <= 2'd0;
            pw  <= 4'd0;
        end else begin
            pw <= pw + 4'd1;
            if (wrap) begin
                pc  <= '0;
                idx <= idx + 2'd1;
            end else begin
                pc  <= pc + PC_W'(1);
            end
        end
    end

    // Shadow registers and frame-start pulse
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            load_pending <= 1'b1;
            sh_digits    <= '0;
            sh_dp        <= '0;
            sh_blank     <= '0;
            sh_bright    <= '0;
            FrameStart   <= 1'b0;
        end else begin
            FrameStart <= load;
            if (load) begin
                load_pending <= 1'b0;
                sh_digits    <= Digits;
                sh_dp        <= DP;
                sh_blank     <= Blank;
                sh_bright    <= Brightness;
            end
        end
    end

    // The decode uses the shadow values as they stand before any load on
    // this edge. A load only happens on pc == SCAN_DIV-1 (or right after
    // reset at pc == 0), both inside dead time or the tail of digit 3, so
    // digit 0 sees the new snapshot from its first lit cycle.
    always_comb begin
        cur_code   = sh_digits[{idx, 2'b00} +: 4];
        on_pwm     = (sh_bright == 4'hF) || (pw < sh_bright);
        past_blank = (pc >= PC_BLANK);
        lit        = past_blank && on_pwm && !sh_blank[idx];
    end

    bcd_to_seg7 u_decode (
        .code (cur_code),
        .seg  (cur_pattern)
    );

    always_comb begin
        drv_next = DRV_OFF;
        seg_next = SEG_OFF;
        if (lit) begin
            drv_next = ~(4'b0001 << idx);
            seg_next = {~sh_dp[idx], ~cur_pattern};
        end
    end

    // Drivers and segments share one register stage so they always switch
    // together; the dead time at pc < BLANK_CYCLES keeps the slot wrap from
    // ever enabling two digits at once.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            SegmentDrivers <= DRV_OFF;
            SevenSegment   <= SEG_OFF;
        end else begin
            SegmentDrivers <= drv_next;
            SevenSegment   <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

    localparam int D     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  bright = 4'hF;
    logic [3:0]  drv;
    logic [7:0]  seg;
    logic        fs;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV     (D),
        .BLANK_CYCLES (B)
    ) dut (
        .Clk_100M       (clk),
        .Reset          (rst),
        .Digits         (digits),
        .DP             (dp),
        .Blank          (blank),
        .Brightness     (bright),
        .SegmentDrivers (drv),
        .SevenSegment   (seg),
        .FrameStart     (fs)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: n counts clock edges since reset release; the shadow
    // copy holds whatever the inputs were at the most recent load edge.
    int          n = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_bright = '0;
    logic [6:0]  pat [16];
    logic [3:0]  exp_drv;
    logic [7:0]  exp_seg;
    logic        exp_fs;
    int          last_en = -1;
    int          dark_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        int  c;
        int  pc;
        int  ix;
        int  pwv;
        int  en;
        logic on;
        logic lit;
        @(posedge clk);
        exp_drv = 4'hF;
        exp_seg = 8'hFF;
        exp_fs  = 1'b0;
        if (!rst) begin
            n++;
            c   = n - 1;
            pc  = c % D;
            ix  = (c / D) % 4;
            pwv = c % 16;
            on  = (m_bright == 4'd15) || (pwv < int'(m_bright));
            lit = (pc >= B) && on && !m_blank[ix];
            if (lit) begin
                exp_drv[ix] = 1'b0;
                exp_seg = {~m_dp[ix], ~pat[m_digits[ix*4 +: 4]]};
            end
            exp_fs = (n == 1) || (n % FRAME == 0);
            if (exp_fs) begin
                m_digits = digits;
                m_dp     = dp;
                m_blank  = blank;
                m_bright = bright;
            end
        end
        #1;
        check("drivers", drv, exp_drv);
        check("segments", seg, exp_seg);
        check("framestart", fs, exp_fs);
        check("one_enabled", ($countones(~drv) <= 1), 1);
        en = -1;
        for (int i = 0; i < 4; i++) if (!drv[i]) en = i;
        if (en >= 0) begin
            if (last_en >= 0 && en != last_en) check("dead_time", (dark_run >= B), 1);
            last_en  = en;
            dark_run = 0;
        end else begin
            dark_run++;
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic model_reset();
        n        = 0;
        m_digits = '0;
        m_dp     = '0;
        m_blank  = '0;
        m_bright = '0;
    endtask

    initial begin
        int cnt;
        int en;
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // Held in reset: everything dark
        repeat (3) step();
        check("rst_drv", drv, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_fs", fs, 1'b0);

        // Release with 1234, full brightness
        @(negedge clk);
        rst = 1'b0;
        run_to(1);
        check("first_fs", fs, 1'b1);
        run_to(3);
        check("d0_drv", drv, 4'b1110);
        check("d0_seg", seg, 8'h99);
        run_to(9);
        check("slot_wrap_dark", drv, 4'hF);
        run_to(11);
        check("d1_drv", drv, 4'b1101);
        check("d1_seg", seg, 8'hB0);

        // Mid-frame change is deferred to the next frame boundary
        run_to(12);
        digits = 16'h5678;
        run_to(19);
        check("d2_old", seg, 8'hA4);
        run_to(27);
        check("d3_old", seg, 8'hF9);
        run_to(35);
        check("d0_new", seg, 8'h80);

        // Brightness 4, only digit 0 visible
        run_to(40);
        bright = 4'd4;
        blank  = 4'b1110;
        run_to(64);
        cnt = 0;
        while (n < 192) begin
            step();
            if (drv != 4'hF) cnt++;
        end
        check("pwm4_lit_count", cnt, 8);

        // Brightness 0: dark for the whole frame
        bright = 4'd0;
        blank  = 4'b0000;
        run_to(224);
        cnt = 0;
        while (n < 256) begin
            step();
            if (drv != 4'hF) cnt++;
        end
        check("pwm0_dark", cnt, 0);

        // Blank digit 2, DP on digit 0 only
        bright = 4'hF;
        blank  = 4'b0100;
        dp     = 4'b0001;
        digits = 16'($urandom);
        run_to(288);
        while (n < 320) begin
            step();
            check("blank2_off", drv[2], 1'b1);
            en = -1;
            for (int i = 0; i < 4; i++) if (!drv[i]) en = i;
            if (en >= 0) check("dp_bit", seg[7], (en == 0) ? 1'b0 : 1'b1);
        end

        // Reset while digit 2 is lit at pc 5
        blank = 4'b0000;
        run_to(373);
        check("pre_rst_drv", drv, 4'b1011);
        rst = 1'b1;
        #1;
        check("async_rst_drv", drv, 4'hF);
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_fs", fs, 1'b0);
        model_reset();
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (n < 31) begin
            step();
            if (fs) cnt++;
        end
        check("restart_fs_once", cnt, 1);

        // Random soak
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < FRAME; k++) begin
                step();
                digits = 16'($urandom);
                dp     = 4'($urandom);
                blank  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
                bright = 4'($urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
